// File: rtl/npu_pe_feeder.sv
// npu_pe_feeder: buffers feature/weight pairs and streams them into one npu_pe as a framed burst.
// Optional WAIT-state timeout is compiled in when NPU_FEEDER_TIMEOUT_EN is defined.
module npu_pe_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int MAX_LEN    = 16,
  parameter int ADDR_WIDTH = $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_feature,
  input  logic [DATA_WIDTH-1:0] i_wr_weight,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic [ACC_WIDTH-1:0]  i_bias,
  output logic                  o_busy,
  output logic                  o_pe_valid,
  output logic                  o_pe_last,
  output logic [DATA_WIDTH-1:0] o_pe_feature,
  output logic [DATA_WIDTH-1:0] o_pe_weight,
  output logic [ACC_WIDTH-1:0]  o_pe_bias,
  input  logic                  i_pe_valid,
  input  logic [DATA_WIDTH-1:0] i_pe_result,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_WIDTH:0] MAX_LEN_W = (ADDR_WIDTH+1)'(MAX_LEN);

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH:0]   start_len;
  logic [ACC_WIDTH-1:0]  bias_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  streaming;
  logic                  last_beat;

  logic [DATA_WIDTH-1:0] feature_mem [MAX_LEN];
  logic [DATA_WIDTH-1:0] weight_mem  [MAX_LEN];

`ifdef NPU_FEEDER_TIMEOUT_EN
  logic [5:0] wait_cnt;
  logic       timeout_q;
`endif

  always_comb begin
    start_len = (i_len > MAX_LEN_W) ? MAX_LEN_W : i_len;
  end

  assign streaming = (state == S_STREAM);
  assign last_beat = streaming && (idx_q == (len_q - 1'b1));

  // Buffer contents deliberately survive reset so a command can be replayed afterwards.
  always_ff @(posedge clk) begin
    if (!rst && i_wr_en && (state == S_IDLE) && ({1'b0, i_wr_addr} < MAX_LEN_W)) begin
      feature_mem[i_wr_addr] <= i_wr_feature;
      weight_mem[i_wr_addr]  <= i_wr_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      bias_q   <= '0;
      result_q <= '0;
`ifdef NPU_FEEDER_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            bias_q <= i_bias;
            len_q  <= start_len;
            idx_q  <= '0;
`ifdef NPU_FEEDER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (start_len == '0) begin
              result_q <= '0;
              state    <= S_DONE;
            end else begin
              state <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          idx_q <= idx_q + 1'b1;
          if (last_beat) begin
            state <= S_WAIT;
`ifdef NPU_FEEDER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A result arriving in the final counted cycle still takes priority over the timeout.
          if (i_pe_valid) begin
            result_q <= i_pe_result;
            state    <= S_DONE;
          end
`ifdef NPU_FEEDER_TIMEOUT_EN
          else if (wait_cnt == 6'd63) begin
            result_q  <= '0;
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = (state != S_IDLE);
  assign o_pe_valid   = streaming;
  assign o_pe_last    = last_beat;
  assign o_pe_feature = streaming ? feature_mem[idx_q[ADDR_WIDTH-1:0]] : '0;
  assign o_pe_weight  = streaming ? weight_mem[idx_q[ADDR_WIDTH-1:0]]  : '0;
  assign o_pe_bias    = bias_q;
  assign o_done       = (state == S_DONE);
  assign o_result     = result_q;

`ifdef NPU_FEEDER_TIMEOUT_EN
  assign o_timeout = (state == S_DONE) && timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule
